// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial A+B+Cin sequencer around one sum-only full-adder cell
module fa_sum (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_s
);
    assign o_s = i_a ^ i_b ^ i_cin;
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_a, r_b, r_part, r_sum, w_part_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic             r_carry, r_cout, r_busy, r_done;
    logic             w_s, w_maj, w_last, w_accept;
    fa_sum u_cell (
        .i_a  (r_a[0]),
        .i_b  (r_b[0]),
        .i_cin(r_carry),
        .o_s  (w_s)
    );
    assign w_maj    = (r_a[0] & r_b[0]) | (r_carry & (r_a[0] ^ r_b[0]));
    assign w_last   = (r_state == SHIFT) && (r_cnt == CNT_W'(WIDTH - 1));
    assign w_accept = i_start && (r_state != SHIFT);
    generate
        if (WIDTH == 1) begin : g_one
            assign w_part_nxt = w_s;
        end else begin : g_multi
            assign w_part_nxt = {w_s, r_part[WIDTH-1:1]};
        end
    endgenerate
    // next-state: DONE accepts a new request directly so back-to-back adds have no gap
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    w_state_nxt = i_start ? SHIFT : IDLE;
            SHIFT:   w_state_nxt = w_last ? DONE : SHIFT;
            DONE:    w_state_nxt = i_start ? SHIFT : IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end
    // state register with Busy/Done registered from the next state
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= w_state_nxt == SHIFT;
            r_done  <= w_state_nxt == DONE;
        end
    end
    // datapath: latch operands on accept, one bit per SHIFT edge, publish result on the last bit
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_part  <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else if (w_accept) begin
            r_a     <= i_a;
            r_b     <= i_b;
            r_carry <= i_cin;
            r_cnt   <= '0;
        end else if (r_state == SHIFT) begin
            r_a     <= r_a >> 1;
            r_b     <= r_b >> 1;
            r_carry <= w_maj;
            r_part  <= w_part_nxt;
            r_cnt   <= r_cnt + CNT_W'(1);
            if (w_last) begin
                r_sum  <= w_part_nxt;
                r_cout <= w_maj;
            end
        end
    end
    assign o_busy = r_busy;
    assign o_done = r_done;
    assign o_sum  = r_sum;
    assign o_cout = r_cout;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: directed and exhaustive checks of the bit-serial adder at WIDTH 8, 4 and 1
module tb_serial_adder_ctrl;
    logic       clk = 1'b0, rst_n = 1'b0;
    logic       s8 = 1'b0, c8 = 1'b0, bz8, d8, co8;
    logic [7:0] a8 = '0, b8 = '0, sm8;
    logic       s4 = 1'b0, c4 = 1'b0, bz4, d4, co4;
    logic [3:0] a4 = '0, b4 = '0, sm4;
    logic       s1 = 1'b0, c1 = 1'b0, bz1, d1, co1;
    logic       a1 = 1'b0, b1 = 1'b0, sm1;
    int         n_chk = 0, n_err = 0;
    int         lat, pulses;
    always #5 clk = ~clk;
    serial_adder_ctrl #(.WIDTH(8), .CNT_W(4)) u8 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(s8), .i_a(a8), .i_b(b8), .i_cin(c8),
        .o_busy(bz8), .o_done(d8), .o_sum(sm8), .o_cout(co8)
    );
    serial_adder_ctrl #(.WIDTH(4), .CNT_W(3)) u4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(s4), .i_a(a4), .i_b(b4), .i_cin(c4),
        .o_busy(bz4), .o_done(d4), .o_sum(sm4), .o_cout(co4)
    );
    serial_adder_ctrl #(.WIDTH(1), .CNT_W(1)) u1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(s1), .i_a(a1), .i_b(b1), .i_cin(c1),
        .o_busy(bz1), .o_done(d1), .o_sum(sm1), .o_cout(co1)
    );
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, obs, exp);
        end
    endtask
    function automatic logic dn(input int w);
        return w == 8 ? d8 : (w == 4 ? d4 : d1);
    endfunction
    task automatic wait_done(input int w, output int n);
        tick;
        n = 1;
        while (!dn(w) && n < 40) begin
            tick;
            n++;
        end
    endtask
    task automatic add8(input logic [7:0] a, input logic [7:0] b, input logic c,
                        input logic [7:0] es, input logic ec);
        int l;
        a8 = a; b8 = b; c8 = c; s8 = 1'b1;
        tick;
        s8 = 1'b0;
        chk("add8_busy", bz8, 1);
        wait_done(8, l);
        chk($sformatf("add8_lat %h+%h+%h", a, b, c), l, 8);
        chk($sformatf("add8_sum %h+%h+%h", a, b, c), sm8, es);
        chk($sformatf("add8_cout %h+%h+%h", a, b, c), co8, ec);
    endtask
    initial begin
        tick;
        tick;
        chk("rst_busy8", bz8, 0);
        chk("rst_done8", d8, 0);
        chk("rst_sum8", {co8, sm8}, 0);
        chk("rst_4", {bz4, d4, co4, sm4}, 0);
        chk("rst_1", {bz1, d1, co1, sm1}, 0);
        rst_n = 1'b1;
        tick;
        a8 = 8'h5A; b8 = 8'h3C; c8 = 1'b0; s8 = 1'b1;
        tick;
        s8 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("t1_busy%0d", i), bz8, 1);
            chk($sformatf("t1_done%0d", i), d8, 0);
            tick;
        end
        chk("t1_done", d8, 1);
        chk("t1_busy_off", bz8, 0);
        chk("t1_sum", sm8, 8'h96);
        chk("t1_cout", co8, 0);
        tick;
        chk("t1_done_pulse", d8, 0);
        chk("t1_sum_held", sm8, 8'h96);
        add8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
        tick;
        add8(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
        tick;
        add8(8'h00, 8'h00, 1'b1, 8'h01, 1'b0);
        tick;
        a8 = 8'h10; b8 = 8'h20; c8 = 1'b1; s8 = 1'b1;
        tick;
        a8 = 8'h77; b8 = 8'h11; c8 = 1'b0;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            tick;
            pulses += int'(d8);
        end
        s8 = 1'b0;
        chk("t3_sum", sm8, 8'h31);
        chk("t3_cout", co8, 0);
        for (int i = 0; i < 12; i++) begin
            tick;
            pulses += int'(d8);
        end
        chk("t3_pulses", pulses, 1);
        chk("t3_idle", bz8, 0);
        add8(8'h40, 8'h41, 1'b0, 8'h81, 1'b0);
        a8 = 8'h01; b8 = 8'h02; c8 = 1'b0; s8 = 1'b1;
        tick;
        s8 = 1'b0;
        chk("t4_busy", bz8, 1);
        chk("t4_sum_stable0", sm8, 8'h81);
        for (int i = 1; i < 8; i++) begin
            tick;
            chk($sformatf("t4_sum_stable%0d", i), sm8, 8'h81);
            chk($sformatf("t4_nodone%0d", i), d8, 0);
        end
        tick;
        chk("t4_done", d8, 1);
        chk("t4_sum", sm8, 8'h03);
        chk("t4_cout", co8, 0);
        a8 = 8'hFF; b8 = 8'hFF; c8 = 1'b0; s8 = 1'b1;
        tick;
        s8 = 1'b0;
        for (int i = 0; i < 4; i++) tick;
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        chk("t5_busy", bz8, 0);
        chk("t5_done", d8, 0);
        chk("t5_sum", sm8, 0);
        chk("t5_cout", co8, 0);
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            tick;
            pulses += int'(d8);
        end
        chk("t5_no_done", pulses, 0);
        add8(8'h12, 8'h34, 1'b1, 8'h47, 1'b0);
        tick;
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                for (int c = 0; c < 2; c++) begin
                    a4 = 4'(a); b4 = 4'(b); c4 = c[0]; s4 = 1'b1;
                    tick;
                    s4 = 1'b0;
                    wait_done(4, lat);
                    chk($sformatf("w4_lat %0d+%0d+%0d", a, b, c), lat, 4);
                    chk($sformatf("w4_res %0d+%0d+%0d", a, b, c), {co4, sm4}, a + b + c);
                end
        for (int a = 0; a < 2; a++)
            for (int b = 0; b < 2; b++)
                for (int c = 0; c < 2; c++) begin
                    a1 = a[0]; b1 = b[0]; c1 = c[0]; s1 = 1'b1;
                    tick;
                    s1 = 1'b0;
                    wait_done(1, lat);
                    chk($sformatf("w1_lat %0d+%0d+%0d", a, b, c), lat, 1);
                    chk($sformatf("w1_res %0d+%0d+%0d", a, b, c), {co1, sm1}, a + b + c);
                end
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
